csr_access_unit: RTL and testbench

Initiator side of the CSR read port: executes Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) on behalf of the core. It accepts one request at a time and performs a read-modify-write sequence against the CSR file's address/read-data port plus write strobe. It returns the old CSR value, or an illegal-instruction flag, to the core's writeback stage. Sits between the execute stage and the CSR file.

---
 rtl/csr_access_unit_if.sv | 34 +++
 rtl/csr_access_unit.sv | 116 +++++++++++
 tb/tb_csr_access_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/csr_access_unit_if.sv
// Request/response and CSR-file port bundle for csr_access_unit.
// The unit is the master; the core and CSR file together form the slave side.
interface csr_access_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [11:0]       req_addr;
  logic [DATA_W-1:0] req_src;
  logic              req_src_zero;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_illegal;
  logic [11:0]       csr_addr;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_we;
  logic [DATA_W-1:0] csr_wdata;

  modport master (
    input  req_valid, req_op, req_addr, req_src, req_src_zero,
    input  resp_ready, csr_rdata,
    output req_ready, resp_valid, resp_rdata, resp_illegal,
    output csr_addr, csr_we, csr_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_src, req_src_zero,
    output resp_ready, csr_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_illegal,
    input  csr_addr, csr_we, csr_wdata
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer: IDLE -> READ -> WRITE -> RESP,
// one request in flight, old CSR value or illegal flag returned to the core.
module csr_access_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  csr_access_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [1:0]        r_op;
  logic [11:0]       r_addr;
  logic [DATA_W-1:0] r_src;
  logic              r_src_zero;
  logic [DATA_W-1:0] r_old;
  logic              r_need_wr;
  logic              r_illegal;

  logic              w_need_wr;
  logic              w_illegal;
  logic [DATA_W-1:0] w_new;

  // RW always writes; RS/RC write only when the rs1/zimm field is non-zero.
  assign w_need_wr = (r_op == 2'b01) || (r_op[1] && !r_src_zero);
  assign w_illegal = (r_op == 2'b00) || (w_need_wr && (r_addr[11:10] == 2'b11));

  always_comb begin
    w_new = r_old;
    unique case (r_op)
      2'b01:   w_new = r_src;
      2'b10:   w_new = r_old | r_src;
      2'b11:   w_new = r_old & ~r_src;
      default: w_new = r_old;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_old      <= '0;
      r_need_wr  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op       <= bus.req_op;
            r_addr     <= bus.req_addr;
            r_src      <= bus.req_src;
            r_src_zero <= bus.req_src_zero;
          end
        end
        S_READ: begin
          r_old     <= bus.csr_rdata;
          r_need_wr <= w_need_wr;
          r_illegal <= w_illegal;
        end
        default: ;
      endcase
    end
  end

  // Address register doubles as csr_addr so it holds the last request outside READ/WRITE.
  assign bus.csr_addr = r_addr;

  always_comb begin
    w_next           = r_state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = '0;
    bus.resp_illegal = 1'b0;
    bus.csr_we       = 1'b0;
    bus.csr_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = S_READ;
      end
      S_READ: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        // Masked by reset so a strobe pending at the reset edge never lands.
        bus.csr_we    = r_need_wr && !r_illegal && !reset;
        bus.csr_wdata = w_new;
        w_next        = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid   = 1'b1;
        bus.resp_rdata   = r_illegal ? '0 : r_old;
        bus.resp_illegal = r_illegal;
        if (bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed and randomized bench for csr_access_unit with a behavioural CSR file
// and a rule-level model of the Zicsr result.
module tb_csr_access_unit;

  logic clock;
  logic reset;
  logic preload;
  int   checks;
  int   errors;

  csr_access_unit_if #(.DATA_W(32)) bus ();

  csr_access_unit #(.DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [4096];

  assign bus.csr_rdata = mem[bus.csr_addr];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
      mem[12'hF11] <= 32'h616B_6562;
      mem[12'hF12] <= 32'h0531_8008;
      mem[12'h300] <= 32'h0000_00FF;
    end else if (bus.csr_we) begin
      mem[bus.csr_addr] <= bus.csr_wdata;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with it idle again.
  task automatic run(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                     input logic zero, input int hold, input logic poke);
    logic [31:0] old, nv;
    logic        wr, ill, we;
    old = mem[addr];
    wr  = (op == 2'd1) || (op >= 2'd2 && !zero);
    ill = (op == 2'd0) || (wr && addr >= 12'hC00);
    we  = wr && !ill;
    nv  = (op == 2'd1) ? src : (op == 2'd2) ? (old | src) : (old & ~src);

    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_src      = src;
    bus.req_src_zero = zero;
    bus.resp_ready   = (hold == 0);
    chk1("idle_req_ready", bus.req_ready, 1'b1);
    chk1("idle_we", bus.csr_we, 1'b0);

    @(negedge clock);
    bus.req_valid = 1'b0;
    chk1("read_resp_valid", bus.resp_valid, 1'b0);
    chk1("read_req_ready", bus.req_ready, 1'b0);
    chk1("read_we", bus.csr_we, 1'b0);
    chk32("read_addr", 32'(bus.csr_addr), 32'(addr));

    @(negedge clock);
    chk1("write_we", bus.csr_we, we);
    if (we) chk32("write_wdata", bus.csr_wdata, nv);
    chk32("write_addr", 32'(bus.csr_addr), 32'(addr));
    chk1("write_resp_valid", bus.resp_valid, 1'b0);

    @(negedge clock);
    chk1("resp_valid", bus.resp_valid, 1'b1);
    chk32("resp_rdata", bus.resp_rdata, ill ? 32'h0 : old);
    chk1("resp_illegal", bus.resp_illegal, ill);
    chk1("resp_req_ready", bus.req_ready, 1'b0);
    chk1("resp_we", bus.csr_we, 1'b0);

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid    = 1'b1;
        bus.req_op       = 2'b01;
        bus.req_addr     = 12'h340;
        bus.req_src      = 32'hDEAD_BEEF;
        bus.req_src_zero = 1'b0;
      end
      @(negedge clock);
      chk1("hold_resp_valid", bus.resp_valid, 1'b1);
      chk32("hold_rdata", bus.resp_rdata, ill ? 32'h0 : old);
      chk1("hold_illegal", bus.resp_illegal, ill);
      chk1("hold_req_ready", bus.req_ready, 1'b0);
      chk1("hold_we", bus.csr_we, 1'b0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;

    @(negedge clock);
    chk1("done_resp_valid", bus.resp_valid, 1'b0);
    chk1("done_req_ready", bus.req_ready, 1'b1);
    chk32("csr_file_value", mem[addr], we ? nv : old);
  endtask

  logic [11:0] addr_pool [8];

  initial begin
    logic [31:0] old305;
    logic [1:0]  rop;
    logic [11:0] raddr;
    logic [31:0] rsrc;
    logic        rzero;

    checks = 0;
    errors = 0;
    addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h340;
    addr_pool[3] = 12'hF11; addr_pool[4] = 12'hF12; addr_pool[5] = 12'hC00;
    addr_pool[6] = 12'h7C0; addr_pool[7] = 12'hB00;

    reset = 1'b1;
    preload = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_addr = '0;
    bus.req_src = '0;
    bus.req_src_zero = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    preload = 1'b0;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("rst_resp_illegal", bus.resp_illegal, 1'b0);
    chk32("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk1("rst_we", bus.csr_we, 1'b0);
    chk32("rst_csr_addr", 32'(bus.csr_addr), 32'h0);
    chk32("rst_wdata", bus.csr_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    run(2'b10, 12'hF12, 32'h0, 1'b1, 0, 1'b0);
    run(2'b10, 12'hF11, 32'h0, 1'b1, 0, 1'b0);
    run(2'b01, 12'hF12, 32'h1, 1'b0, 0, 1'b0);
    run(2'b11, 12'h300, 32'h0F, 1'b0, 0, 1'b0);
    run(2'b10, 12'h300, 32'h100, 1'b0, 0, 1'b0);
    run(2'b00, 12'h300, 32'h5, 1'b0, 5, 1'b1);

    // Reset landing on the WRITE cycle of a CSRRW.
    old305 = mem[12'h305];
    bus.req_valid    = 1'b1;
    bus.req_op       = 2'b01;
    bus.req_addr     = 12'h305;
    bus.req_src      = 32'hCAFE_F00D;
    bus.req_src_zero = 1'b0;
    bus.resp_ready   = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk1("pre_rst_write_we", bus.csr_we, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk1("post_rst_we", bus.csr_we, 1'b0);
    chk1("post_rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("post_rst_req_ready", bus.req_ready, 1'b1);
    chk32("post_rst_csr_value", mem[12'h305], old305);
    reset = 1'b0;
    run(2'b01, 12'h305, 32'h1234_5678, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 7)];
      rzero = ($urandom_range(0, 3) == 0);
      rsrc  = rzero ? 32'h0 : $urandom;
      run(rop, raddr, rsrc, rzero, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
